// File: rtl/sfx_sequencer_pkg.sv
// Shared types and constant note tables for the sound-effect sequencer.
package sfx_pkg;

   typedef enum logic [1:0] {
      SFX_NONE = 2'd0,
      SFX_JUMP = 2'd1,
      SFX_WIN  = 2'd2,
      SFX_LOSE = 2'd3
   } sfx_e;

   typedef struct packed {
      logic [15:0] hp;
      logic [7:0]  dur;
   } note_t;

   localparam int NOTES = 4;

   localparam note_t JUMP_T [NOTES] = '{
      '{16'd100, 8'd3}, '{16'd80, 8'd3},
      '{16'd0, 8'd0}, '{16'd0, 8'd0}};
   localparam note_t WIN_T [NOTES] = '{
      '{16'd120, 8'd4}, '{16'd100, 8'd4},
      '{16'd80, 8'd4}, '{16'd60, 8'd8}};
   localparam note_t LOSE_T [NOTES] = '{
      '{16'd80, 8'd6}, '{16'd120, 8'd6},
      '{16'd160, 8'd12}, '{16'd0, 8'd0}};

   // Indices past the table read as an end marker (dur=0).
   function automatic note_t sfx_note(
      input sfx_e s, input logic [2:0] idx);
      note_t n;
      n = '0;
      if (idx < 3'(NOTES)) begin
         case (s)
            SFX_JUMP: n = JUMP_T[idx[1:0]];
            SFX_WIN:  n = WIN_T[idx[1:0]];
            SFX_LOSE: n = LOSE_T[idx[1:0]];
            default:  n = '0;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// Event inputs and audio/status outputs of the sequencer.
interface sfx_if;
   import sfx_pkg::*;

   logic jumpForward;
   logic jumpBackward;
   logic jumpRight;
   logic jumpLeft;
   logic win;
   logic lose;
   logic sound;
   logic busy;
   sfx_e active_sfx;
   logic done;

   modport master (
      output jumpForward, jumpBackward, jumpRight, jumpLeft,
      output win, lose,
      input  sound, busy, active_sfx, done
   );

   modport slave (
      input  jumpForward, jumpBackward, jumpRight, jumpLeft,
      input  win, lose,
      output sound, busy, active_sfx, done
   );
endinterface

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: toggles sound every (hp << HP_SHIFT) clocks.
module sfx_tone_gen #(
   parameter int HP_SHIFT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        load,
   input  logic [15:0] half,
   output logic        sound
);

   localparam int CW = 16 + HP_SHIFT;

   logic [CW-1:0] cnt;
   logic [CW-1:0] load_val;
   logic [CW-1:0] reload_val;
   logic [15:0]   hp_q;

   always_comb begin
      load_val   = (CW'(half) << HP_SHIFT) - CW'(1);
      reload_val = (CW'(hp_q) << HP_SHIFT) - CW'(1);
   end

   // hp=0 is a rest: output parked low, counter idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         sound <= 1'b0;
         hp_q  <= '0;
      end else if (load) begin
         hp_q  <= half;
         sound <= (half != 16'd0);
         cnt   <= (half == 16'd0) ? '0 : load_val;
      end else if (!run || hp_q == 16'd0) begin
         cnt   <= '0;
         sound <= 1'b0;
      end else if (cnt == '0) begin
         sound <= ~sound;
         cnt   <= reload_val;
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: edge-detected events, LOSE>WIN>JUMP priority,
// table-driven notes with preemption and a one-cycle done pulse.
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int TICK_DIV  = 50000,
   parameter int HP_SHIFT  = 8,
   parameter int MAX_NOTES = 4
) (
   input logic clk,
   input logic reset,
   sfx_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PLAY = 1'b1;

   logic [0:0]    state;
   logic [PW-1:0] presc;
   logic [7:0]    dur_cnt;
   logic [2:0]    note_idx;
   sfx_e          active;
   logic          done_q;
   logic [2:0]    hist;

   logic          jump_lvl;
   logic          jump_req;
   logic          win_req;
   logic          lose_req;
   sfx_e          req;
   logic          start;
   logic          tick;
   logic          note_end;
   logic          last;
   logic          stop;
   logic          adv;
   logic          load;
   logic          run;
   logic [2:0]    nxt_idx;
   note_t         nxt;
   note_t         first;
   logic [15:0]   hp_sel;

   always_comb begin
      jump_lvl = bus.jumpForward | bus.jumpBackward |
                 bus.jumpRight | bus.jumpLeft;
      jump_req = jump_lvl & ~hist[0];
      win_req  = bus.win & ~hist[1];
      lose_req = bus.lose & ~hist[2];
      req = SFX_NONE;
      if (lose_req)      req = SFX_LOSE;
      else if (win_req)  req = SFX_WIN;
      else if (jump_req) req = SFX_JUMP;
      // Enum codes are ordered by priority, so >= means "may preempt".
      start = (req != SFX_NONE) &&
              (state == IDLE || req >= active);
      tick     = (presc == PW'(TICK_DIV - 1));
      nxt_idx  = note_idx + 3'd1;
      nxt      = sfx_note(active, nxt_idx);
      first    = sfx_note(req, 3'd0);
      note_end = (state == PLAY) && tick && (dur_cnt <= 8'd1);
      last     = (nxt_idx == 3'(MAX_NOTES)) || (nxt.dur == 8'd0);
      stop     = note_end && last && !start;
      adv      = note_end && !last && !start;
      load     = start || adv;
      hp_sel   = start ? first.hp : nxt.hp;
      run      = (state == PLAY) && !stop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         presc    <= '0;
         dur_cnt  <= '0;
         note_idx <= '0;
         active   <= SFX_NONE;
         done_q   <= 1'b0;
         hist     <= '0;
      end else begin
         hist   <= {bus.lose, bus.win, jump_lvl};
         done_q <= stop;
         if (start) begin
            state    <= PLAY;
            active   <= req;
            note_idx <= '0;
            dur_cnt  <= first.dur;
            presc    <= '0;
         end else if (stop) begin
            state    <= IDLE;
            active   <= SFX_NONE;
            note_idx <= '0;
            dur_cnt  <= '0;
            presc    <= '0;
         end else if (adv) begin
            note_idx <= nxt_idx;
            dur_cnt  <= nxt.dur;
            presc    <= '0;
         end else if (state == PLAY) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) dur_cnt <= dur_cnt - 8'd1;
         end
      end
   end

   sfx_tone_gen #(
      .HP_SHIFT(HP_SHIFT)
   ) u_tone (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .load  (load),
      .half  (hp_sel),
      .sound (bus.sound)
   );

   assign bus.busy       = (state == PLAY);
   assign bus.active_sfx = active;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer with HP_SHIFT=0, TICK_DIV=400.
module tb_sfx_sequencer;
   import sfx_pkg::*;

   typedef struct {
      logic [5:0] ev;
      int         adv;
      logic       snd;
      logic       bsy;
      logic [1:0] sfx;
      logic       dn;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int tests = 0;
   int fails = 0;
   vec_t vecs [12];

   sfx_if bus ();

   sfx_sequencer #(
      .TICK_DIV  (400),
      .HP_SHIFT  (0),
      .MAX_NOTES (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // ev bits: lose, win, fwd, bwd, right, left
   task automatic drive(input logic [5:0] ev);
      bus.lose         = ev[5];
      bus.win          = ev[4];
      bus.jumpForward  = ev[3];
      bus.jumpBackward = ev[2];
      bus.jumpRight    = ev[1];
      bus.jumpLeft     = ev[0];
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic s, input logic b,
                        input logic [1:0] a, input logic d);
      tests++;
      if (bus.sound !== s || bus.busy !== b ||
          bus.active_sfx !== sfx_e'(a) || bus.done !== d) begin
         fails++;
         $display("FAIL %s: got sound=%0b busy=%0b sfx=%0d done=%0b, want sound=%0b busy=%0b sfx=%0d done=%0b",
                  nm, bus.sound, bus.busy, bus.active_sfx, bus.done,
                  s, b, a, d);
      end
   endtask

   initial begin
      vecs[0]  = '{6'b000001, 1,    1'b1, 1'b1, 2'd1, 1'b0};
      vecs[1]  = '{6'b000001, 99,   1'b1, 1'b1, 2'd1, 1'b0};
      vecs[2]  = '{6'b000001, 1,    1'b0, 1'b1, 2'd1, 1'b0};
      vecs[3]  = '{6'b000001, 100,  1'b1, 1'b1, 2'd1, 1'b0};
      vecs[4]  = '{6'b000001, 999,  1'b0, 1'b1, 2'd1, 1'b0};
      vecs[5]  = '{6'b000001, 1,    1'b1, 1'b1, 2'd1, 1'b0};
      vecs[6]  = '{6'b000001, 80,   1'b0, 1'b1, 2'd1, 1'b0};
      vecs[7]  = '{6'b000001, 1119, 1'b1, 1'b1, 2'd1, 1'b0};
      vecs[8]  = '{6'b000001, 1,    1'b0, 1'b0, 2'd0, 1'b1};
      vecs[9]  = '{6'b000001, 1,    1'b0, 1'b0, 2'd0, 1'b0};
      vecs[10] = '{6'b000001, 500,  1'b0, 1'b0, 2'd0, 1'b0};
      vecs[11] = '{6'b000000, 2,    1'b0, 1'b0, 2'd0, 1'b0};

      drive(6'b0);
      step(3);
      check("reset_state", 0, 0, 0, 0);
      reset = 1'b0;
      step(2);
      check("idle_after_reset", 0, 0, 0, 0);

      // Held jumpLeft: full JUMP effect, no retrigger.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].ev);
         step(vecs[i].adv);
         check($sformatf("jump_vec%0d", i), vecs[i].snd, vecs[i].bsy,
               vecs[i].sfx, vecs[i].dn);
      end

      // WIN and jump on the same edge: WIN wins, 8000 clocks long.
      drive(6'b011000);
      step(1);
      check("win_prio_t0", 1, 1, 2, 0);
      step(7999);
      check("win_t7999", 0, 1, 2, 0);
      step(1);
      check("win_done", 0, 0, 0, 1);
      drive(6'b0);
      step(3);

      // LOSE playing, WIN edge ignored.
      drive(6'b100000);
      step(1);
      check("lose_t0", 1, 1, 3, 0);
      step(999);
      drive(6'b110000);
      step(1);
      check("lose_ignores_win", 1, 1, 3, 0);
      step(8599);
      check("lose_t9599", 0, 1, 3, 0);
      step(1);
      check("lose_done", 0, 0, 0, 1);
      drive(6'b0);
      step(3);

      // JUMP preempted by LOSE at t=700.
      drive(6'b000010);
      step(1);
      check("jr_t0", 1, 1, 1, 0);
      step(699);
      drive(6'b100010);
      step(1);
      check("lose_preempt", 1, 1, 3, 0);
      step(9599);
      check("preempt_t9599", 0, 1, 3, 0);
      step(1);
      check("preempt_done", 0, 0, 0, 1);
      drive(6'b0);
      step(3);

      // Jump edge exactly on the JUMP completion edge.
      drive(6'b000100);
      step(1);
      check("jb_t0", 1, 1, 1, 0);
      drive(6'b0);
      step(2399);
      check("jb_t2399", 1, 1, 1, 0);
      drive(6'b000010);
      step(1);
      check("restart_on_end", 1, 1, 1, 0);
      step(1);
      check("restart_no_done", 1, 1, 1, 0);
      step(2398);
      check("restart_t2399", 1, 1, 1, 0);
      step(1);
      check("restart_done", 0, 0, 0, 1);
      drive(6'b0);
      step(3);

      // Asynchronous reset in the middle of WIN.
      drive(6'b010000);
      step(1);
      step(500);
      check("win_t500", 1, 1, 2, 0);
      reset = 1'b1;
      #1;
      check("async_reset", 0, 0, 0, 0);
      drive(6'b0);
      step(3);
      reset = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
         end
         tests++;
         if (seen != 0) begin
            fails++;
            $display("FAIL post_reset_idle: got %0d bad cycles, want 0",
                     seen);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
